// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: applies button moves, teleports and animation once per frame at vertical-blank entry.
// Define SPRITE_WRAP_EN to make button moves wrap at the screen edges instead of clamping.
module sprite_motion_ctrl #(
    parameter int X0       = 450,
    parameter int Y0       = 250,
    parameter int W        = 32,
    parameter int H        = 32,
    parameter int H_MIN    = 144,
    parameter int H_MAX    = 784,
    parameter int V_MIN    = 35,
    parameter int V_MAX    = 515,
    parameter int STEP     = 2,
    parameter int ANIM_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x,
    input  logic [9:0] cmd_y,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [1:0] anim_frame,
    output logic       moving,
    output logic       frame_tick
);
    localparam logic [1:0] ACTIVE = 2'd0;
    localparam logic [1:0] UPDATE = 2'd1;
    localparam logic [1:0] BLANK  = 2'd2;
    localparam logic signed [10:0] X_LO = 11'(H_MIN);
    localparam logic signed [10:0] X_HI = 11'(H_MAX - W);
    localparam logic signed [10:0] Y_LO = 11'(V_MIN);
    localparam logic signed [10:0] Y_HI = 11'(V_MAX - H);
    localparam logic signed [10:0] S    = 11'(STEP);
    logic [1:0] state;
    logic in_vb, in_vb_q, upd, pending, mv, anim_wrap;
    logic [9:0] tx, ty, tcx, tcy, bx, by;
    logic [7:0] cnt;
    logic signed [10:0] dx, dy, nx, ny;
    logic unused_h;

    function automatic logic [9:0] clamp(input logic signed [10:0] v, input logic signed [10:0] lo,
                                         input logic signed [10:0] hi);
        return v < lo ? lo[9:0] : v > hi ? hi[9:0] : v[9:0];
    endfunction

    function automatic logic [9:0] wrap(input logic signed [10:0] v, input logic signed [10:0] lo,
                                        input logic signed [10:0] hi);
        return v > hi ? lo[9:0] : v < lo ? hi[9:0] : v[9:0];
    endfunction

    assign unused_h   = ^hCount;
    assign in_vb      = vCount >= 10'(V_MAX);
    assign upd        = state == UPDATE;
    assign frame_tick = upd;
    assign cmd_ready  = rst & ~pending;
    assign dx         = btn_right == btn_left ? 11'sd0 : btn_right ? S : -S;
    assign dy         = btn_down == btn_up ? 11'sd0 : btn_down ? S : -S;
    assign nx         = $signed({1'b0, xpos}) + dx;
    assign ny         = $signed({1'b0, ypos}) + dy;
    assign tcx        = clamp($signed({1'b0, tx}), X_LO, X_HI);
    assign tcy        = clamp($signed({1'b0, ty}), Y_LO, Y_HI);
`ifdef SPRITE_WRAP_EN
    assign bx         = wrap(nx, X_LO, X_HI);
    assign by         = wrap(ny, Y_LO, Y_HI);
`else
    assign bx         = clamp(nx, X_LO, X_HI);
    assign by         = clamp(ny, Y_LO, Y_HI);
`endif
    assign mv         = pending | (dx != 11'sd0) | (dy != 11'sd0);
    assign anim_wrap  = cnt == 8'(ANIM_DIV - 1);

    // Frame sequencer: one UPDATE cycle per blank entry, then wait out the blank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_vb_q <= 1'b1;
            state   <= ACTIVE;
        end else begin
            in_vb_q <= in_vb;
            state   <= upd ? BLANK : state == BLANK ? (in_vb ? BLANK : ACTIVE) : (in_vb && !in_vb_q ? UPDATE : ACTIVE);
        end
    end

    // Single-entry teleport slot, emptied only by an enabled update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= 1'b0;
            tx      <= '0;
            ty      <= '0;
        end else if (cmd_valid && cmd_ready) begin
            pending <= 1'b1;
            tx      <= cmd_x;
            ty      <= cmd_y;
        end else if (upd && en) begin
            pending <= 1'b0;
        end
    end

    // Position and animation state, changed only in the UPDATE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            xpos       <= 10'(X0);
            ypos       <= 10'(Y0);
            moving     <= 1'b0;
            cnt        <= '0;
            anim_frame <= '0;
        end else if (upd && !en) begin
            moving     <= 1'b0;
        end else if (upd) begin
            xpos       <= pending ? tcx : bx;
            ypos       <= pending ? tcy : by;
            moving     <= mv;
            cnt        <= !mv || anim_wrap ? 8'd0 : cnt + 8'd1;
            anim_frame <= !mv ? 2'd0 : anim_wrap ? anim_frame + 2'd1 : anim_frame;
        end
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed frame-by-frame checks of sprite_motion_ctrl.
module tb_sprite_motion_ctrl;
    logic clk = 1'b0;
    logic rst, en, btn_up, btn_down, btn_left, btn_right, cmd_valid, cmd_ready, moving, frame_tick;
    logic [9:0] hCount, vCount, cmd_x, cmd_y, xpos, ypos;
    logic [1:0] anim_frame;
    int total = 0, bad = 0, cx = 450, cy = 250, wx;

    sprite_motion_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .hCount(hCount), .vCount(vCount),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .xpos(xpos), .ypos(ypos), .anim_frame(anim_frame), .moving(moving), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input int nx, input int ny, input int nf, input int nm);
        vCount = 10'd100;
        repeat (3) tick();
        chk("tick_idle", frame_tick, 0);
        vCount = 10'd515;
        tick();
        chk("tick_upd", frame_tick, 1);
        chk("x_hold", xpos, cx);
        chk("y_hold", ypos, cy);
        tick();
        chk("tick_off", frame_tick, 0);
        chk("x_new", xpos, nx);
        chk("y_new", ypos, ny);
        chk("anim", anim_frame, nf);
        chk("moving", moving, nm);
        vCount = 10'd520;
        repeat (2) tick();
        cx = nx;
        cy = ny;
    endtask

    initial begin
`ifdef SPRITE_WRAP_EN
        wx = 144;
`else
        wx = 752;
`endif
        rst = 1'b0; en = 1'b1; hCount = 10'd300; vCount = 10'd100;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        cmd_valid = 0; cmd_x = '0; cmd_y = '0;
        repeat (2) tick();
        chk("rst_x", xpos, 450);
        chk("rst_y", ypos, 250);
        chk("rst_anim", anim_frame, 0);
        chk("rst_moving", moving, 0);
        chk("rst_tick", frame_tick, 0);
        chk("rst_ready", cmd_ready, 0);
        rst = 1'b1;
        tick();
        chk("ready_after_rst", cmd_ready, 1);
        frame(450, 250, 0, 0);
        btn_right = 1;
        frame(452, 250, 0, 1);
        frame(454, 250, 0, 1);
        frame(456, 250, 0, 1);
        btn_right = 0;
        btn_left = 1;
        vCount = 10'd100;
        cmd_valid = 1; cmd_x = 10'd900; cmd_y = 10'd10;
        tick();
        cmd_valid = 0;
        chk("ready_pending", cmd_ready, 0);
        frame(752, 35, 0, 1);
        chk("ready_cleared", cmd_ready, 1);
        btn_left = 0;
        btn_right = 1;
        frame(wx, 35, 0, 1);
        btn_right = 0;
        frame(wx, 35, 0, 0);
        btn_down = 1;
        for (int k = 1; k <= 17; k++) frame(wx, 35 + 2 * k, k / 8, 1);
        btn_down = 0;
        frame(wx, 69, 0, 0);
        btn_left = 1; btn_right = 1;
        frame(wx, 69, 0, 0);
        btn_left = 0; btn_right = 0;
        en = 0; btn_up = 1;
        vCount = 10'd100;
        cmd_valid = 1; cmd_x = 10'd300; cmd_y = 10'd200;
        tick();
        cmd_valid = 0;
        frame(wx, 69, 0, 0);
        chk("ready_en0", cmd_ready, 0);
        en = 1;
        frame(300, 200, 0, 1);
        chk("ready_en1", cmd_ready, 1);
        btn_up = 0;
        vCount = 10'd520; rst = 1'b0; btn_right = 1;
        repeat (2) tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("blank_no_tick", frame_tick, 0);
        end
        chk("blank_rst_x", xpos, 450);
        chk("blank_rst_y", ypos, 250);
        cx = 450; cy = 250;
        frame(452, 250, 0, 1);
        btn_right = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
